ram_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-ported word RAM interface used by the ALU (address, write data, read strobe, write strobe, read data).
- Port A is the ALU instruction/data path. Port B is a secondary master, e.g. the program loader or a debug reader.
- Grants one RAM access at a time using round-robin on conflict.
- Generates one-cycle strobes, counts a fixed read latency, and returns the read data to the winning requester with a valid pulse.

---
 rtl/ram_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-ported word RAM between ports A and B.
// Issues one-cycle strobes, waits READ_LAT edges for read data and returns it to the granted port.
module ram_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    input  logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_out,
    output logic              read_req,
    output logic              write_req,
    output logic              busy
);

    localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {GRANT_A, GRANT_B} port_t;

    state_t            state, state_nxt;
    port_t             last_grant, last_grant_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              grant_b;
    logic              sel_we;

    logic              a_ack_nxt, a_rvalid_nxt, b_ack_nxt, b_rvalid_nxt;
    logic              read_req_nxt, write_req_nxt, busy_nxt;
    logic [DATA_W-1:0] a_rdata_nxt, b_rdata_nxt, ram_out_nxt;
    logic [ADDR_W-1:0] ram_address_nxt;

    // Next-state and next-output logic
    always_comb begin
        state_nxt       = state;
        last_grant_nxt  = last_grant;
        cnt_nxt         = cnt;
        ram_address_nxt = ram_address;
        ram_out_nxt     = ram_out;
        a_rdata_nxt     = a_rdata;
        b_rdata_nxt     = b_rdata;
        a_ack_nxt       = 1'b0;
        b_ack_nxt       = 1'b0;
        a_rvalid_nxt    = 1'b0;
        b_rvalid_nxt    = 1'b0;
        read_req_nxt    = 1'b0;
        write_req_nxt   = 1'b0;
        grant_b         = b_req && (!a_req || (last_grant == GRANT_A));
        sel_we          = grant_b ? b_we : a_we;

        unique case (state)
            IDLE: begin
                // The port acked last edge still presents that request this cycle, so skip sampling
                if (!a_ack && !b_ack && (a_req || b_req)) begin
                    last_grant_nxt  = grant_b ? GRANT_B : GRANT_A;
                    ram_address_nxt = grant_b ? b_addr : a_addr;
                    ram_out_nxt     = grant_b ? b_wdata : a_wdata;
                    a_ack_nxt       = !grant_b;
                    b_ack_nxt       = grant_b;
                    read_req_nxt    = !sel_we;
                    write_req_nxt   = sel_we;
                    if (!sel_we) begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(READ_LAT - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    if (last_grant == GRANT_B) begin
                        b_rdata_nxt  = ram_in;
                        b_rvalid_nxt = 1'b1;
                    end else begin
                        a_rdata_nxt  = ram_in;
                        a_rvalid_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
        endcase

        busy_nxt = (state_nxt == WAIT);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= GRANT_B;
            cnt         <= '0;
            ram_address <= '0;
            ram_out     <= '0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
            read_req    <= 1'b0;
            write_req   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            cnt         <= cnt_nxt;
            ram_address <= ram_address_nxt;
            ram_out     <= ram_out_nxt;
            a_rdata     <= a_rdata_nxt;
            b_rdata     <= b_rdata_nxt;
            a_ack       <= a_ack_nxt;
            b_ack       <= b_ack_nxt;
            a_rvalid    <= a_rvalid_nxt;
            b_rvalid    <= b_rvalid_nxt;
            read_req    <= read_req_nxt;
            write_req   <= write_req_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter at READ_LAT 1, 2 and 4, checked every cycle against a
// timestamp-based reference model of grants, strobes, read returns and busy windows.
module tb_ram_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int          N_CYC  = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] hash(input logic [ADDR_W-1:0] a);
        return DATA_W'((a * 32'h9E37_79B1) ^ 32'h7777_F00D);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_lat
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;

        logic              reset;
        logic              a_req, a_we, b_req, b_we;
        logic [ADDR_W-1:0] a_addr, b_addr;
        logic [DATA_W-1:0] a_wdata, b_wdata;
        logic              a_ack, a_rvalid, b_ack, b_rvalid;
        logic [DATA_W-1:0] a_rdata, b_rdata;
        logic [DATA_W-1:0] ram_in, ram_out;
        logic [ADDR_W-1:0] ram_address;
        logic              read_req, write_req, busy;

        ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(L)) dut (
            .clk(clk), .reset(reset),
            .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
            .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
            .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
            .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
            .ram_in(ram_in), .ram_address(ram_address), .ram_out(ram_out),
            .read_req(read_req), .write_req(write_req), .busy(busy)
        );

        // Bench-side RAM and requesters
        logic [DATA_W-1:0] ram_mem [logic [ADDR_W-1:0]];
        int                rd_cyc;
        bit                r_act [2];
        bit                r_we  [2];
        logic [ADDR_W-1:0] r_addr [2];
        logic [DATA_W-1:0] r_wd   [2];

        // Reference model: event times and the values they make visible
        logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
        int                c, next_sample, stb_cyc, rv_cyc, busy_lo, busy_hi, rst_cyc;
        bit                stb_we, stb_b, rv_b, last_b, win_b;
        logic [ADDR_W-1:0] pend_addr, e_addr;
        logic [DATA_W-1:0] pend_out, pend_rdata, e_out, e_ardata, e_brdata;
        string             pfx;

        initial begin
            pfx = $sformatf("L%0d.", L);
            reset = 1'b1;
            a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
            b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
            ram_in = '0;
            rd_cyc = -1;
            for (int p = 0; p < 2; p++) begin
                r_act[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = '0; r_wd[p] = '0;
            end
            last_b = 1'b1; next_sample = 0; stb_cyc = -1; rv_cyc = -1;
            busy_lo = 0; busy_hi = -1; rst_cyc = -1;
            stb_we = 1'b0; stb_b = 1'b0; rv_b = 1'b0; win_b = 1'b0;
            pend_addr = '0; pend_out = '0; pend_rdata = '0;
            e_addr = '0; e_out = '0; e_ardata = '0; e_brdata = '0;

            forever begin
                @(negedge clk);
                c = cyc;

                if (c == rst_cyc) begin
                    e_addr = '0; e_out = '0; e_ardata = '0; e_brdata = '0;
                end
                if (c == stb_cyc) begin
                    e_addr = pend_addr;
                    e_out  = pend_out;
                end
                if (c == rv_cyc) begin
                    if (rv_b) e_brdata = pend_rdata;
                    else      e_ardata = pend_rdata;
                end

                chk({pfx, "a_ack"},       64'(a_ack),       64'(c == stb_cyc && !stb_b));
                chk({pfx, "b_ack"},       64'(b_ack),       64'(c == stb_cyc && stb_b));
                chk({pfx, "read_req"},    64'(read_req),    64'(c == stb_cyc && !stb_we));
                chk({pfx, "write_req"},   64'(write_req),   64'(c == stb_cyc && stb_we));
                chk({pfx, "a_rvalid"},    64'(a_rvalid),    64'(c == rv_cyc && !rv_b));
                chk({pfx, "b_rvalid"},    64'(b_rvalid),    64'(c == rv_cyc && rv_b));
                chk({pfx, "busy"},        64'(busy),        64'(c >= busy_lo && c <= busy_hi));
                chk({pfx, "ram_address"}, 64'(ram_address), 64'(e_addr));
                chk({pfx, "ram_out"},     64'(ram_out),     64'(e_out));
                chk({pfx, "a_rdata"},     64'(a_rdata),     64'(e_ardata));
                chk({pfx, "b_rdata"},     64'(b_rdata),     64'(e_brdata));

                // RAM: data is only correct in the cycle L-1 after the read strobe
                if (write_req) ram_mem[ram_address] = ram_out;
                if (read_req) rd_cyc = c;
                if (rd_cyc >= 0 && c == rd_cyc + L - 1)
                    ram_in = ram_mem.exists(ram_address) ? ram_mem[ram_address] : hash(ram_address);
                else
                    ram_in = ~hash(ram_address) ^ DATA_W'($urandom);

                // Requesters drop on ack and may present a new request at once
                if (a_ack) r_act[0] = 1'b0;
                if (b_ack) r_act[1] = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    if (!r_act[p] && $urandom_range(99) < 45) begin
                        r_act[p]  = 1'b1;
                        r_we[p]   = ($urandom_range(2) == 0);
                        r_addr[p] = ADDR_W'($urandom_range(15) * 4);
                        r_wd[p]   = DATA_W'($urandom);
                    end
                end
                a_req = r_act[0]; a_we = r_we[0]; a_addr = r_addr[0]; a_wdata = r_wd[0];
                b_req = r_act[1]; b_we = r_we[1]; b_addr = r_addr[1]; b_wdata = r_wd[1];
                reset = (c < 3) || ($urandom_range(149) == 0);

                // Model decision for the edge that ends cycle c
                if (reset) begin
                    last_b = 1'b1; stb_cyc = -1; rv_cyc = -1;
                    busy_lo = 0; busy_hi = -1;
                    rst_cyc = c + 1; next_sample = c + 1;
                end else if (c >= next_sample && (r_act[0] || r_act[1])) begin
                    win_b     = r_act[1] && (!r_act[0] || !last_b);
                    last_b    = win_b;
                    stb_cyc   = c + 1;
                    stb_b     = win_b;
                    stb_we    = r_we[win_b];
                    pend_addr = r_addr[win_b];
                    pend_out  = r_wd[win_b];
                    if (stb_we) begin
                        ref_mem[pend_addr] = pend_out;
                        next_sample = c + 2;
                    end else begin
                        pend_rdata  = ref_mem.exists(pend_addr) ? ref_mem[pend_addr] : hash(pend_addr);
                        rv_cyc      = c + 1 + L;
                        rv_b        = win_b;
                        busy_lo     = c + 1;
                        busy_hi     = c + L;
                        next_sample = c + 1 + L;
                    end
                end
            end
        end
    end

    initial begin
        repeat (N_CYC) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
